ram_rr_arbiter: RTL

Two-requester round-robin arbiter and sequencer for the single-port separate-I/O RAM (ports clk/we/addr/data_in/data_out).
- Accepts one read or write per cycle from either requester using a valid/ready handshake.
- Drives the RAM port and returns read data one cycle later, tagged to the requester that issued the read.
- Supports a lock hint so one requester can hold the RAM for a bounded burst.

---
 rtl/ram_rr_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: two-requester round-robin arbiter/sequencer for a single-port RAM with bounded lock bursts.
// Optional statistics counters are enabled by defining RAM_ARB_STATS_EN.
module ram_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_0,
    output logic                  req_ready_0,
    input  logic                  req_we_0,
    input  logic                  req_lock_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [DATA_WIDTH-1:0] req_wdata_0,
    input  logic                  req_valid_1,
    output logic                  req_ready_1,
    input  logic                  req_we_1,
    input  logic                  req_lock_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [DATA_WIDTH-1:0] req_wdata_1,
    output logic                  rsp_valid_0,
    output logic [DATA_WIDTH-1:0] rsp_rdata_0,
    output logic                  rsp_valid_1,
    output logic [DATA_WIDTH-1:0] rsp_rdata_1,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [15:0]           grant_cnt_0,
    output logic [15:0]           grant_cnt_1,
    output logic [15:0]           stall_cnt_0,
    output logic [15:0]           stall_cnt_1
`endif
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t                state, state_nxt;
    logic                  last_grant;
    logic [3:0]            burst_cnt, burst_nxt, burst_base;
    logic                  grant_0, grant_1, any_grant, lock_g, keep;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Grant selection: owner first, otherwise round-robin against last_grant; nothing granted in reset
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (!rst) begin
            case (state)
                OWN0: begin
                    grant_0 = req_valid_0;
                    grant_1 = !req_valid_0 && req_valid_1;
                end
                OWN1: begin
                    grant_1 = req_valid_1;
                    grant_0 = !req_valid_1 && req_valid_0;
                end
                default: begin
                    grant_0 = req_valid_0 && (!req_valid_1 || last_grant);
                    grant_1 = req_valid_1 && (!req_valid_0 || !last_grant);
                end
            endcase
        end
    end

    // Lock bookkeeping: a burst continues only for the current owner, a new grantee starts from zero
    always_comb begin
        any_grant  = grant_0 || grant_1;
        lock_g     = grant_1 ? req_lock_1 : req_lock_0;
        burst_base = ((state == OWN0 && grant_0) || (state == OWN1 && grant_1)) ? burst_cnt : 4'd0;
        keep       = any_grant && lock_g && (({28'd0, burst_base} + 32'd1) < 32'(MAX_BURST));
        state_nxt  = keep ? (grant_1 ? OWN1 : OWN0) : IDLE;
        burst_nxt  = keep ? burst_base + 4'd1 : 4'd0;
    end

    // RAM port drive: muxed from the grantee, address/data hold their last values when idle
    always_comb begin
        req_ready_0 = grant_0;
        req_ready_1 = grant_1;
        ram_we      = any_grant && (grant_1 ? req_we_1 : req_we_0);
        ram_addr    = any_grant ? (grant_1 ? req_addr_1 : req_addr_0) : addr_q;
        ram_data_in = any_grant ? (grant_1 ? req_wdata_1 : req_wdata_0) : wdata_q;
        rsp_rdata_0 = rsp_valid_0 ? ram_data_out : '0;
        rsp_rdata_1 = rsp_valid_1 ? ram_data_out : '0;
    end

    // State, round-robin pointer, held RAM drive and one-cycle read response tags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            burst_cnt   <= 4'd0;
            last_grant  <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
        end else begin
            state       <= state_nxt;
            burst_cnt   <= burst_nxt;
            last_grant  <= any_grant ? grant_1 : last_grant;
            addr_q      <= ram_addr;
            wdata_q     <= ram_data_in;
            rsp_valid_0 <= grant_0 && !req_we_0;
            rsp_valid_1 <= grant_1 && !req_we_1;
        end
    end

`ifdef RAM_ARB_STATS_EN
    // Saturating grant and stall counters per requester
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_0 <= 16'd0;
            grant_cnt_1 <= 16'd0;
            stall_cnt_0 <= 16'd0;
            stall_cnt_1 <= 16'd0;
        end else begin
            grant_cnt_0 <= (grant_0 && grant_cnt_0 != 16'hFFFF) ? grant_cnt_0 + 16'd1 : grant_cnt_0;
            grant_cnt_1 <= (grant_1 && grant_cnt_1 != 16'hFFFF) ? grant_cnt_1 + 16'd1 : grant_cnt_1;
            stall_cnt_0 <= (req_valid_0 && !grant_0 && stall_cnt_0 != 16'hFFFF) ? stall_cnt_0 + 16'd1 : stall_cnt_0;
            stall_cnt_1 <= (req_valid_1 && !grant_1 && stall_cnt_1 != 16'hFFFF) ? stall_cnt_1 + 16'd1 : stall_cnt_1;
        end
    end
`endif

endmodule
